board_input_conditioner: RTL
============================

Name: board_input_conditioner

Overview:
Parametrised board-level input conditioning block for RVX FPGA board tops. It generates a divided clock-enable pulse rather than a derived clock, so the whole design stays on one clock. It synchronises and debounces a vector of push-buttons, emits press and release pulses, and produces a stretched active-low system reset for the rvx_ocelot core. It sits between the board pins and the SoC instance.

Parameters:
NUM_BUTTONS, 4, number of button channels (>=1)
CLOCK_DIVIDER, 2, clock_enable period in clock cycles (>=1)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a new button level (>=1)
BUTTON_ACTIVE_LOW, 0, 1 = raw buttons are inverted before synchronisation
RESET_BUTTON_ENABLE, 1, 1 = the channel at RESET_BUTTON_INDEX also drives system reset
RESET_BUTTON_INDEX, 0, channel used as reset button (<NUM_BUTTONS)
RESET_HOLD_CYCLES, 16, cycles system_reset_n stays low after all reset sources are released (>=1)

Ports:
clock  input  1  board clock; all logic on rising edge
reset  input  1  synchronous, active-high block reset
buttons  input  NUM_BUTTONS  raw asynchronous button pins
clock_enable  output  1  one-cycle pulse every CLOCK_DIVIDER cycles
buttons_debounced  output  NUM_BUTTONS  debounced active-high button levels
button_pressed  output  NUM_BUTTONS  one-cycle pulse on debounced 0->1
button_released  output  NUM_BUTTONS  one-cycle pulse on debounced 1->0
system_reset_n  output  1  stretched active-low reset for the SoC

Behaviour:
- Reset (reset=1 at an edge): divider counter=0, clock_enable=0, sync flops=0, debounce counters=0, buttons_debounced=0, pressed/released=0, hold counter=0, system_reset_n=0.
- Divider: counter runs 0..CLOCK_DIVIDER-1 and wraps. clock_enable is registered, high for exactly one cycle at edge N*CLOCK_DIVIDER after reset release (edge 1 = first edge with reset=0). With CLOCK_DIVIDER=1, clock_enable is high every cycle from edge 1.
- Input path: optional inversion, then a 2-flop synchroniser per channel. No cross-channel coupling.
- Debounce per channel: mismatch = (sync2 != debounced). On mismatch, counter increments. A non-mismatch cycle clears the counter. On mismatch with counter==DEBOUNCE_CYCLES-1, debounced flips and the counter clears.
- Debounce timing: a new raw level first sampled at edge 0 and held appears on buttons_debounced at edge DEBOUNCE_CYCLES+1. A glitch shorter than DEBOUNCE_CYCLES sync cycles never propagates.
- Counter width: clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
- Pulses: button_pressed[i] / button_released[i] are asserted at the same edge the debounced bit flips, for one cycle only. Both are never high together on one channel.
- Reset source: src = reset | (RESET_BUTTON_ENABLE & buttons_debounced[RESET_BUTTON_INDEX]).
- Hold counter: src=1 clears the hold counter and drives system_reset_n=0. Otherwise the counter increments, saturating at RESET_HOLD_CYCLES. system_reset_n=1 when the counter equals RESET_HOLD_CYCLES.
- Reset timing: system_reset_n rises at the RESET_HOLD_CYCLES-th edge with src=0. Re-assertion of src mid-stretch restarts the full count.
- The reset button channel still produces normal debounced levels and pulses.
- Block reset mid-debounce discards partial counts. After reset a held button reappears after DEBOUNCE_CYCLES+2 edges.

Test Plan:
1. CLOCK_DIVIDER=4: release reset -> clock_enable high at edges 4, 8, 12 only; with CLOCK_DIVIDER=1 it is high every edge from edge 1.
2. DEBOUNCE_CYCLES=8, buttons[2] 0->1 held -> buttons_debounced[2]=1 at edge 9; button_pressed[2] is a one-cycle pulse at edge 9; other channels stay 0.
3. DEBOUNCE_CYCLES=8, 5-cycle glitch on buttons[1] -> no change on buttons_debounced or pulses; a 6-cycle bounce burst then a stable level -> exactly one press pulse.
4. RESET_HOLD_CYCLES=16, block reset released -> system_reset_n=0 through edge 15, =1 at edge 16.
5. Reset button pressed for 20 cycles with DEBOUNCE_CYCLES=8 -> system_reset_n falls when debounced goes 1; after debounced release it rises 16 edges later. Re-press at hold count 10 -> count restarts from 0.
6. BUTTON_ACTIVE_LOW=1, raw=4'b1111 -> debounced=0; raw[3]=0 held -> debounced[3]=1 after DEBOUNCE_CYCLES+1 edges; block reset mid-count -> counter cleared, full delay re-applied.

Source files
------------

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: single-clock board front end with a clock-enable
// divider, button sync/debounce, edge pulses and a stretched SoC reset.
module board_input_conditioner #(
  parameter int NUM_BUTTONS         = 4,
  parameter int CLOCK_DIVIDER       = 2,
  parameter int DEBOUNCE_CYCLES     = 1000,
  parameter int BUTTON_ACTIVE_LOW   = 0,
  parameter int RESET_BUTTON_ENABLE = 1,
  parameter int RESET_BUTTON_INDEX  = 0,
  parameter int RESET_HOLD_CYCLES   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic                   clock_enable,
  output logic [NUM_BUTTONS-1:0] buttons_debounced,
  output logic [NUM_BUTTONS-1:0] button_pressed,
  output logic [NUM_BUTTONS-1:0] button_released,
  output logic                   system_reset_n
);

  localparam int DIV_W =
    (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLOCK_DIVIDER - 1);
  localparam logic [DEB_W-1:0] DEB_LAST =
    DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX =
    HOLD_W'(RESET_HOLD_CYCLES);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt      <= '0;
      clock_enable <= 1'b0;
    end else begin
      clock_enable <= (div_cnt == DIV_LAST);
      div_cnt      <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  logic [NUM_BUTTONS-1:0] raw_level;
  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;

  assign raw_level = (BUTTON_ACTIVE_LOW != 0) ? ~buttons : buttons;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_level;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    logic [DEB_W-1:0] cnt;
    logic             deb_q;
    logic             press_q;
    logic             rel_q;
    logic             mismatch;

    assign mismatch = sync2[i] ^ deb_q;

    // A flip needs DEBOUNCE_CYCLES back-to-back mismatching samples.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt     <= '0;
        deb_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        if (!mismatch) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          cnt     <= '0;
          deb_q   <= sync2[i];
          press_q <= sync2[i];
          rel_q   <= ~sync2[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign buttons_debounced[i] = deb_q;
    assign button_pressed[i]    = press_q;
    assign button_released[i]   = rel_q;
  end

  logic              reset_src;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;

  assign reset_src = reset |
    ((RESET_BUTTON_ENABLE != 0) &
     buttons_debounced[RESET_BUTTON_INDEX]);

  assign hold_next =
    (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset_src) begin
      hold_cnt       <= '0;
      system_reset_n <= 1'b0;
    end else begin
      hold_cnt       <= hold_next;
      system_reset_n <= (hold_next == HOLD_MAX);
    end
  end

endmodule
